// File: rtl/leb128_decoder.sv
// WebAssembly LEB128 immediate decoder (u32/s32/u64/s64) fed byte-by-byte over valid/ready.
// Produces a 64-bit sign/zero-extended value with its byte length, or flags a malformed encoding.
module leb128_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        is_64,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [63:0] result,
  output logic [3:0]  len,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        error,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone, StError} state_t;

  state_t      state;
  logic [63:0] acc;
  logic [3:0]  count;
  logic        sgn;
  logic        w64;

  logic [3:0]  cnt1;
  logic [6:0]  shift;
  logic [6:0]  fill_shift;
  logic [63:0] merged;
  logic [63:0] fill_val;
  logic [63:0] final_val;
  logic        is_last;
  logic        final_ok;

  always_comb begin
    cnt1       = count + 4'd1;
    shift      = {3'b000, count} * 7'd7;
    fill_shift = {3'b000, cnt1} * 7'd7;
    // Shift in 64 bits so payload bits past bit 63 fall off instead of wrapping.
    merged     = acc | ({57'd0, byte_data[6:0]} << shift);
    is_last    = (cnt1 == (w64 ? 4'd10 : 4'd5));

    unique case ({sgn, w64})
      2'b00:   final_ok = (byte_data[6:4] == 3'b000);
      2'b10:   final_ok = (byte_data[6:3] == 4'b0000) || (byte_data[6:3] == 4'b1111);
      2'b01:   final_ok = (byte_data[6:1] == 6'd0);
      default: final_ok = (byte_data[6:0] == 7'h00) || (byte_data[6:0] == 7'h7f);
    endcase

    fill_val = merged;
    if (sgn && byte_data[6] && (fill_shift < 7'd64)) begin
      fill_val = merged | (~64'd0 << fill_shift);
    end

    final_val = fill_val;
    if (!w64) begin
      final_val[63:32] = {32{sgn & fill_val[31]}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      acc          <= 64'd0;
      count        <= 4'd0;
      sgn          <= 1'b0;
      w64          <= 1'b0;
      result       <= 64'd0;
      len          <= 4'd0;
      byte_ready   <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StError: begin
          if (start) begin
            state      <= StAccum;
            sgn        <= is_signed;
            w64        <= is_64;
            acc        <= 64'd0;
            count      <= 4'd0;
            error      <= 1'b0;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
          end
        end
        StAccum: begin
          if (byte_valid) begin
            acc   <= merged;
            count <= cnt1;
            // Continuation on the last allowed byte, or a bad final byte, is malformed.
            if (is_last && (byte_data[7] || !final_ok)) begin
              state      <= StError;
              error      <= 1'b1;
              len        <= cnt1;
              byte_ready <= 1'b0;
            end else if (!byte_data[7]) begin
              state        <= StDone;
              result       <= final_val;
              len          <= cnt1;
              result_valid <= 1'b1;
              byte_ready   <= 1'b0;
            end
          end
        end
        StDone: begin
          if (result_ready) begin
            state        <= StIdle;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_leb128_decoder.sv
// Scoreboard bench for leb128_decoder: directed byte streams push expected results into a
// queue; a negedge monitor compares whenever the decoder presents a result or raises error.
module tb_leb128_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic        is_64 = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic [63:0] result;
  logic [3:0]  len;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic        error;
  logic        busy;

  leb128_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .is_64        (is_64),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .result       (result),
    .len          (len),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .error        (error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  len;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic err_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare on every presented result and on each rising error.
  always @(negedge clk) begin
    if (reset) begin
      err_prev = 1'b0;
    end else begin
      if (result_valid) begin
        if (q.size() == 0) flag("unexpected_result");
        else begin
          check("result", result, q[0].res);
          check("len", 64'(len), 64'(q[0].len));
          check("error_with_result", 64'(error), 64'(q[0].err));
          if (result_ready) void'(q.pop_front());
        end
      end
      if (error && !err_prev) begin
        if (q.size() == 0) flag("unexpected_error");
        else begin
          check("error_flag", 64'(error), 64'(q[0].err));
          check("error_len", 64'(len), 64'(q[0].len));
          void'(q.pop_front());
        end
      end
      err_prev = error;
    end
  end

  task automatic expect_out(input logic [63:0] res, input logic [3:0] l, input logic e);
    exp_t x;
    x.res = res;
    x.len = l;
    x.err = e;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dec(input logic s, input logic w);
    start     = 1'b1;
    is_signed = s;
    is_64     = w;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 20) begin
      cyc();
      t++;
    end
    if (t >= 20) flag("byte_ready_timeout");
    cyc();
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && !error && t < 50) begin
      cyc();
      t++;
    end
    if (t >= 50) flag("idle_timeout");
  endtask

  initial begin
    repeat (2) cyc();
    check("rst_result", result, 64'd0);
    check("rst_len", 64'(len), 64'd0);
    check("rst_flags", {60'd0, byte_ready, result_valid, error, busy}, 64'd0);
    reset = 1'b0;
    cyc();

    // u32 624485 with latency check.
    start_dec(1'b0, 1'b0);
    expect_out(64'h98765, 4'd3, 1'b0);
    send(8'hE5);
    send(8'h8E);
    check("no_early_valid", 64'(result_valid), 64'd0);
    send(8'h26);
    check("valid_latency", 64'(result_valid), 64'd1);
    wait_idle();

    // s64 -123456.
    start_dec(1'b1, 1'b1);
    expect_out(64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 1'b0);
    send(8'hC0);
    send(8'hBB);
    send(8'h78);
    wait_idle();

    // s32 -1 then u32 3.
    start_dec(1'b1, 1'b0);
    expect_out(64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 1'b0);
    send(8'h7F);
    wait_idle();
    start_dec(1'b0, 1'b0);
    expect_out(64'd3, 4'd1, 1'b0);
    send(8'h03);
    wait_idle();

    // u32 five-byte boundary cases.
    start_dec(1'b0, 1'b0);
    expect_out(64'h0000_0000_FFFF_FFFF, 4'd5, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hFF);
    send(8'h0F);
    wait_idle();
    start_dec(1'b0, 1'b0);
    expect_out(64'd0, 4'd5, 1'b1);
    for (int i = 0; i < 4; i++) send(8'hFF);
    send(8'h1F);
    wait_idle();
    start_dec(1'b0, 1'b0);
    expect_out(64'd0, 4'd5, 1'b1);
    for (int i = 0; i < 5; i++) send(8'h80);
    check("err_byte_ready", 64'(byte_ready), 64'd0);
    check("err_held", 64'(error), 64'd1);
    wait_idle();

    // 64-bit ten-byte boundary cases.
    start_dec(1'b0, 1'b1);
    expect_out(64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);
    for (int i = 0; i < 9; i++) send(8'hFF);
    send(8'h01);
    wait_idle();
    start_dec(1'b1, 1'b1);
    expect_out(64'h8000_0000_0000_0000, 4'd10, 1'b0);
    for (int i = 0; i < 9; i++) send(8'h80);
    send(8'h7F);
    wait_idle();

    // s64 -2 with byte gaps, stray start pulses and a held-off consumer.
    result_ready = 1'b0;
    start_dec(1'b1, 1'b1);
    expect_out(64'hFFFF_FFFF_FFFF_FFFE, 4'd3, 1'b0);
    send(8'hFE);
    repeat (3) cyc();
    start_dec(1'b0, 1'b0);
    send(8'hFF);
    cyc();
    send(8'h7F);
    repeat (4) cyc();
    start_dec(1'b0, 1'b0);
    check("hold_valid", 64'(result_valid), 64'd1);
    result_ready = 1'b1;
    wait_idle();

    // Reset mid-decode, then a clean decode.
    start_dec(1'b0, 1'b0);
    send(8'hE5);
    send(8'h8E);
    reset = 1'b1;
    #1;
    q.delete();
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_len", 64'(len), 64'd0);
    check("mid_rst_flags", {60'd0, byte_ready, result_valid, error, busy}, 64'd0);
    cyc();
    reset = 1'b0;
    cyc();
    start_dec(1'b0, 1'b0);
    expect_out(64'h98765, 4'd3, 1'b0);
    send(8'hE5);
    send(8'h8E);
    send(8'h26);
    wait_idle();

    repeat (5) cyc();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
